// File: rtl/vid_pkg.sv
// Shared types for the video pixel-fetch scheduler: bus commands, burst length codes,
// fetch FSM states and the burst-length selection helper.
// No logic of its own; purely combinational helper function.
package vid_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE  = 3'b000,
        CMD_WDATA = 3'b001,
        CMD_READ  = 3'b010,
        CMD_RDATA = 3'b011,
        CMD_WREQ  = 3'b100,
        CMD_WRESP = 3'b101
    } bus_cmd_e;

    typedef enum logic [1:0] {
        LEN_1 = 2'b00,
        LEN_2 = 2'b01,
        LEN_4 = 2'b10
    } len_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ARB,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } fetch_state_e;

    localparam logic [1:0] REQ_BID  = 2'b11;
    localparam logic [1:0] REQ_NONE = 2'b00;

    typedef struct packed {
        len_e       code;
        logic [2:0] beats;
    } len_sel_t;

    // Largest burst that does not run past the end of the line.
    function automatic len_sel_t len_code(input logic [12:0] words_left);
        len_sel_t s;
        if (words_left >= 13'd4) begin
            s.code  = LEN_4;
            s.beats = 3'd4;
        end else if (words_left >= 13'd2) begin
            s.code  = LEN_2;
            s.beats = 3'd2;
        end else begin
            s.code  = LEN_1;
            s.beats = 3'd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/vid_fetch_sched_if.sv
// Shared-bus connection of the pixel-fetch scheduler (request/grant, address phase, read data).
// Wires only, no latency.
// Grant is the only backpressure: the master holds its bid until granted.
// master: req_out, cmd_out, len_out, addr_out out; grant_in, cmd_in, data_in in.
// slave : mirror image (arbiter / memory side).
interface vid_fetch_sched_if;
    logic [1:0]  req_out;
    logic        grant_in;
    logic [2:0]  cmd_out;
    logic [1:0]  len_out;
    logic [31:0] addr_out;
    logic [2:0]  cmd_in;
    logic [31:0] data_in;

    modport master (
        output req_out, cmd_out, len_out, addr_out,
        input  grant_in, cmd_in, data_in
    );

    modport slave (
        input  req_out, cmd_out, len_out, addr_out,
        output grant_in, cmd_in, data_in
    );
endinterface

// File: rtl/vid_fetch_watchdog.sv
// Data-beat watchdog: counts DATA cycles since the address phase or the last beat.
// o_expire is combinational, asserted in the TIMEOUT_CYC-th quiet cycle.
// No backpressure; counter clears whenever i_run is low, on a beat, or on expiry.
// Ports: clk, reset_n, i_run (scheduler in DATA), i_beat (read beat seen), o_expire.
module vid_fetch_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    input  logic i_beat,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_run && !i_beat && (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_beat || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vid_fetch_sched.sv
// Pixel-fetch scheduler: walks frame memory line by line, issuing 1/2/4-beat reads to feed RGB FIFOs.
// Bid appears 1 cycle after fifo_level drops to LOW_WATER; address phase 1 cycle after grant; push 1 cycle after beat.
// Backpressure: bids only while fifo_level <= LOW_WATER, one burst outstanding, waits for grant.
// Ports: clk/reset_n; static config (enable, base_addr, line_inc, hsize, vsize); frame_start pulse;
//   fifo_level/pixel_rd from the display side; bus (vid_fetch_sched_if.master); fifo_wr/fifo_wdata;
//   status busy, underrun_err, timeout_err.
// Optional feature macro VID_FETCH_TIMEOUT_EN: adds the data-beat watchdog and timeout_err.
module vid_fetch_sched
    import vid_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int LOW_WATER   = 12,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [31:0]                   base_addr,
    input  logic [31:0]                   line_inc,
    input  logic [12:0]                   hsize,
    input  logic [12:0]                   vsize,
    input  logic                          frame_start,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          pixel_rd,
    vid_fetch_sched_if.master             bus,
    output logic                          fifo_wr,
    output logic [23:0]                   fifo_wdata,
    output logic                          busy,
    output logic                          underrun_err,
    output logic                          timeout_err
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] LW = LVL_W'(LOW_WATER);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_line_ptr, r_addr, r_pend_base;
    logic [12:0]  r_line_cnt, r_words_left;
    logic [2:0]   r_beats, r_beat_cnt;
    logic         r_pend, r_req, r_fifo_wr, r_underrun;
    logic [23:0]  r_fifo_wdata;

    logic [31:0]  w_addr_nxt, w_lp_nxt, w_fs_base, w_lp_adv, w_addr_adv;
    logic [12:0]  w_cnt_nxt, w_words_nxt, w_words_adv, w_cnt_adv;
    logic         w_pend_nxt, w_restart, w_beat, w_last, w_expire, w_burst_end;
    logic         w_sizes_ok, w_line_done;
    len_sel_t     w_sel;

    assign w_sel       = len_code(r_words_left);
    assign w_beat      = (bus.cmd_in == CMD_RDATA);
    assign w_last      = w_beat && (r_beat_cnt == r_beats - 3'd1);
    assign w_burst_end = (r_state == ST_DATA) && (w_last || w_expire);
    assign w_sizes_ok  = (hsize != 13'd0) && (vsize != 13'd0);
    // A restart in the same cycle as the pulse uses the live base; otherwise the one latched at the pulse.
    assign w_fs_base   = frame_start ? base_addr : r_pend_base;
    assign w_words_adv = r_words_left - {10'd0, r_beats};
    // An abandoned (timed-out) burst closes the whole line.
    assign w_line_done = w_expire || (w_words_adv == 13'd0);
    assign w_lp_adv    = r_line_ptr + line_inc;
    assign w_addr_adv  = r_addr + {27'd0, r_beats, 2'b00};
    assign w_cnt_adv   = r_line_cnt + 13'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_lp_nxt    = r_line_ptr;
        w_cnt_nxt   = r_line_cnt;
        w_words_nxt = r_words_left;
        w_pend_nxt  = r_pend;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_WAIT;
            end
            ST_WAIT, ST_DONE: begin
                if (!enable)                        w_state_nxt = ST_IDLE;
                else if (frame_start && w_sizes_ok) w_restart   = 1'b1;
            end
            ST_ARB: begin
                // A grant already given is honoured even if enable drops in the same cycle.
                if (bus.grant_in && r_req) begin
                    w_state_nxt = ST_ADDR;
                    w_pend_nxt  = frame_start;
                end else if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (frame_start) begin
                    w_restart = 1'b1;
                end
            end
            ST_ADDR: begin
                w_state_nxt = ST_DATA;
                if (frame_start) w_pend_nxt = 1'b1;
            end
            ST_DATA: begin
                if (w_burst_end) begin
                    w_pend_nxt = 1'b0;
                    if (w_line_done) begin
                        w_lp_nxt    = w_lp_adv;
                        w_addr_nxt  = w_lp_adv;
                        w_cnt_nxt   = w_cnt_adv;
                        w_words_nxt = hsize;
                    end else begin
                        w_addr_nxt  = w_addr_adv;
                        w_words_nxt = w_words_adv;
                    end
                    if (!enable)                              w_state_nxt = ST_IDLE;
                    else if (r_pend || frame_start)           w_restart   = 1'b1;
                    else if (w_line_done && w_cnt_adv == vsize) w_state_nxt = ST_DONE;
                    else                                      w_state_nxt = ST_ARB;
                end else if (frame_start) begin
                    w_pend_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Start of a new frame: drop whatever is left of the old one.
        if (w_restart) begin
            if (w_sizes_ok) begin
                w_state_nxt = ST_ARB;
                w_addr_nxt  = w_fs_base;
                w_lp_nxt    = w_fs_base;
                w_cnt_nxt   = 13'd0;
                w_words_nxt = hsize;
            end else begin
                w_state_nxt = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_line_ptr   <= '0;
            r_addr       <= '0;
            r_pend_base  <= '0;
            r_line_cnt   <= '0;
            r_words_left <= '0;
            r_beats      <= '0;
            r_beat_cnt   <= '0;
            r_pend       <= 1'b0;
            r_req        <= 1'b0;
            r_fifo_wr    <= 1'b0;
            r_fifo_wdata <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_line_ptr   <= w_lp_nxt;
            r_addr       <= w_addr_nxt;
            r_line_cnt   <= w_cnt_nxt;
            r_words_left <= w_words_nxt;
            r_pend       <= w_pend_nxt;
            if (frame_start) r_pend_base <= base_addr;
            r_req        <= (w_state_nxt == ST_ARB) && (fifo_level <= LW);
            if (r_state == ST_ADDR) begin
                r_beats    <= w_sel.beats;
                r_beat_cnt <= 3'd0;
            end else if (r_state == ST_DATA && w_beat) begin
                r_beat_cnt <= r_beat_cnt + 3'd1;
            end
            r_fifo_wr <= (r_state == ST_DATA) && w_beat;
            if (r_state == ST_DATA && w_beat) r_fifo_wdata <= bus.data_in[23:0];
            if (pixel_rd && fifo_level == '0) r_underrun <= 1'b1;
            else if (frame_start)             r_underrun <= 1'b0;
        end
    end

`ifdef VID_FETCH_TIMEOUT_EN
    logic r_timeout;

    vid_fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_run    (r_state == ST_DATA),
        .i_beat   (w_beat),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         r_timeout <= 1'b0;
        else if (w_expire)    r_timeout <= 1'b1;
        else if (frame_start) r_timeout <= 1'b0;
    end

    assign timeout_err = r_timeout;
`else
    logic w_unused_cfg;
    assign w_expire     = 1'b0;
    assign timeout_err  = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

    logic w_unused_dat;
    assign w_unused_dat = ^bus.data_in[31:24];

    assign bus.req_out  = r_req ? REQ_BID : REQ_NONE;
    assign bus.cmd_out  = (r_state == ST_ADDR) ? CMD_READ : CMD_IDLE;
    assign bus.len_out  = (r_state == ST_ADDR) ? w_sel.code : LEN_1;
    assign bus.addr_out = (r_state == ST_ADDR) ? r_addr : 32'd0;
    assign fifo_wr      = r_fifo_wr;
    assign fifo_wdata   = r_fifo_wdata;
    assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign underrun_err = r_underrun;

endmodule
